// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: word width, wait-state
// default, FSM state encoding and the address-range check.
package dmem_ctrl_pkg;

  localparam int WORD                = 32;
  localparam int WAIT_STATES_DEFAULT = 0;
  localparam int CNT_W               = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } state_e;

  // The last byte of a 4-byte access must lie inside the address space; the
  // sum is formed in 33 bits so addresses near 2^32 cannot wrap into range.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned mem_bytes);
    return (({1'b0, addr} + 33'd3) >= 33'(mem_bytes));
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering between a byte-addressed CPU port and a word RAM:
// merges two RAM words into one load value and splits a store across two words.
module mem_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]      off_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic [WORD-1:0] word0_i,
  input  logic [WORD-1:0] word1_i,
  output logic [WORD-1:0] rdata_o,
  output logic [3:0]      be0_o,
  output logic [3:0]      be1_o,
  output logic [WORD-1:0] wdata0_o,
  output logic [WORD-1:0] wdata1_o
);

  logic [5:0] shLo;
  logic [5:0] shHi;

  // Lane shifts: the first word takes the low bytes moved up by the offset,
  // the second word takes whatever spilled past the top of the first.
  always_comb begin
    shLo     = {1'b0, off_i, 3'b000};
    shHi     = 6'd32 - shLo;
    rdata_o  = WORD'({word1_i, word0_i} >> shLo);
    be0_o    = 4'b1111 << off_i;
    be1_o    = 4'b1111 >> (3'd4 - {1'b0, off_i});
    wdata0_o = wdata_i << shLo;
    wdata1_o = wdata_i >> shHi;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns byte-addressed CPU loads/stores of any
// alignment into one or two word accesses on a simple RAM port.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT,
  parameter int MEM_BYTES   = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [31:0]     req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic [WORD-1:0] req_rdata,
  output logic            req_busy,
  output logic            req_done,
  output logic            req_err,
  output logic            ram_en,
  output logic            ram_we,
  output logic [29:0]     ram_addr,
  output logic [3:0]      ram_be,
  output logic [WORD-1:0] ram_wdata,
  input  logic [WORD-1:0] ram_rdata
);

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]     addr_q;
  logic [WORD-1:0] wdata_q;
  logic            rd_q;
  logic            wr_q;
  logic [WORD-1:0] word0_q;
  logic [WORD-1:0] rdata_q;
  logic            done_q;
  logic            err_q;
  logic            en_q;

  logic [WORD-1:0] rdata_d;
  logic [WORD-1:0] alignWord0;
  logic [3:0]      be0;
  logic [3:0]      be1;
  logic [WORD-1:0] wdata0;
  logic [WORD-1:0] wdata1;
  logic            reqBad;
  logic            misaligned;
  logic            lastCycle;

  // Request qualification and per-state timing helpers.
  always_comb begin
    reqBad     = (req_read & req_write) | addr_fault(req_addr, MEM_BYTES);
    misaligned = (addr_q[1:0] != 2'b00);
    lastCycle  = (cnt_q == CNT_W'(WAIT_STATES));
    alignWord0 = misaligned ? word0_q : ram_rdata;
  end

  mem_align u_align (
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .word0_i  (alignWord0),
    .word1_i  (ram_rdata),
    .rdata_o  (rdata_d),
    .be0_o    (be0),
    .be1_o    (be1),
    .wdata0_o (wdata0),
    .wdata1_o (wdata1)
  );

  // Access FSM: latch the request, run one or two strobed word accesses,
  // then pulse done for a cycle before accepting anything new.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      word0_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_read || req_write) begin
            rd_q    <= req_read;
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= '0;
            if (reqBad) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ACC1;
              en_q    <= 1'b1;
            end
          end
        end
        ACC1: begin
          if (lastCycle) begin
            cnt_q <= '0;
            if (misaligned) begin
              state_q <= ACC2;
            end else begin
              state_q <= DONE;
              en_q    <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACC2: begin
          if (cnt_q == '0) begin
            word0_q <= ram_rdata;
          end
          if (lastCycle) begin
            cnt_q   <= '0;
            state_q <= DONE;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (rd_q && !err_q) begin
            rdata_q <= rdata_d;
          end
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // RAM port and CPU-side outputs; load data is shown live in the done cycle
  // and held from the register afterwards.
  always_comb begin
    req_done  = done_q;
    req_err   = err_q;
    ram_en    = en_q;
    ram_we    = en_q & wr_q;
    req_busy  = ((state_q == IDLE) && (req_read || req_write)) ||
                (state_q == ACC1) || (state_q == ACC2);
    ram_addr  = (state_q == ACC2) ? (addr_q[31:2] + 30'd1) : addr_q[31:2];
    ram_wdata = (state_q == ACC2) ? wdata1 : wdata0;
    if (wr_q) begin
      ram_be = (state_q == ACC2) ? be1 : be0;
    end else begin
      ram_be = 4'b1111;
    end
    req_rdata = (done_q && rd_q && !err_q) ? rdata_d : rdata_q;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: a zero-wait and a two-wait-state instance, each
// with its own behavioural word RAM.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  reqRead, reqWrite, reqBusy, reqDone, reqErr, ramEn, ramWe;
  logic [31:0] reqAddr [2];
  logic [31:0] reqWdata [2];
  logic [31:0] reqRdata [2];
  logic [31:0] ramWdata [2];
  logic [31:0] ramRdata [2];
  logic [29:0] ramAddr [2];
  logic [3:0]  ramBe [2];
  logic [31:0] mem [2][1024];
  logic        memClear;

  int nCompared = 0;
  int nMismatch = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } acc_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    int          en;
  } vec_t;

  exp_t sbQ[$];
  acc_t accLog[$];
  vec_t vecs[20];

  always #5 clk = ~clk;

  dmem_ctrl #(.WAIT_STATES(0), .MEM_BYTES(4096)) dut0 (
    .clk(clk), .rst(rst[0]), .req_read(reqRead[0]), .req_write(reqWrite[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_rdata(reqRdata[0]),
    .req_busy(reqBusy[0]), .req_done(reqDone[0]), .req_err(reqErr[0]),
    .ram_en(ramEn[0]), .ram_we(ramWe[0]), .ram_addr(ramAddr[0]), .ram_be(ramBe[0]),
    .ram_wdata(ramWdata[0]), .ram_rdata(ramRdata[0])
  );

  dmem_ctrl #(.WAIT_STATES(2), .MEM_BYTES(4096)) dut2 (
    .clk(clk), .rst(rst[1]), .req_read(reqRead[1]), .req_write(reqWrite[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_rdata(reqRdata[1]),
    .req_busy(reqBusy[1]), .req_done(reqDone[1]), .req_err(reqErr[1]),
    .ram_en(ramEn[1]), .ram_we(ramWe[1]), .ram_addr(ramAddr[1]), .ram_be(ramBe[1]),
    .ram_wdata(ramWdata[1]), .ram_rdata(ramRdata[1])
  );

  // Behavioural RAMs: byte-enabled writes, registered reads.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (memClear) begin
        for (int i = 0; i < 1024; i++) mem[k][i] <= 32'h0;
      end else if (ramEn[k]) begin
        if (ramWe[k]) begin
          for (int b = 0; b < 4; b++)
            if (ramBe[k][b]) mem[k][ramAddr[k][9:0]][8*b +: 8] <= ramWdata[k][8*b +: 8];
        end else begin
          ramRdata[k] <= mem[k][ramAddr[k][9:0]];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request on instance k, wait (bounded) for done and score it.
  task automatic applyStimulus(input int k, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int expCyc, input logic [31:0] expRd,
                               input logic expErr, input int expEn, input string name);
    exp_t e;
    int   cyc, enCnt, busyLow;
    bit   got;
    accLog.delete();
    sbQ.push_back('{cyc: expCyc, rdata: expRd, err: expErr});
    @(negedge clk);
    reqRead[k] = rd; reqWrite[k] = wr; reqAddr[k] = addr; reqWdata[k] = wdata;
    cyc = 0; enCnt = 0; busyLow = 0; got = 0;
    while (!got && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (ramEn[k]) begin
        enCnt++;
        accLog.push_back('{addr: ramAddr[k], be: ramBe[k], wdata: ramWdata[k], we: ramWe[k]});
      end
      if (reqDone[k]) begin
        got = 1;
        reqRead[k] = 1'b0; reqWrite[k] = 1'b0;
        e = sbQ.pop_front();
        checkOutput({name, " cycle"}, 32'(cyc), 32'(e.cyc));
        checkOutput({name, " rdata"}, reqRdata[k], e.rdata);
        checkOutput({name, " err"}, 32'(reqErr[k]), 32'(e.err));
        checkOutput({name, " busy@done"}, 32'(reqBusy[k]), 32'h0);
      end else if (!reqBusy[k]) begin
        busyLow++;
      end
    end
    checkOutput({name, " done seen"}, 32'(got), 32'h1);
    if (!got) begin
      reqRead[k] = 1'b0; reqWrite[k] = 1'b0;
      void'(sbQ.pop_front());
    end
    checkOutput({name, " ram_en cycles"}, 32'(enCnt), 32'(expEn));
    checkOutput({name, " busy gaps"}, 32'(busyLow), 32'h0);
    @(posedge clk);
  endtask

  initial begin
    exp_t e;
    int   cyc, doneSeen;
    int   doneCycs[$];
    bit   got;

    rst = 2'b00; reqRead = 2'b00; reqWrite = 2'b00; memClear = 1'b1;
    for (int k = 0; k < 2; k++) begin
      reqAddr[k] = 32'h0; reqWdata[k] = 32'h0;
    end

    vecs[0]  = '{1'b0, 1'b1, 32'h010, 32'hDDCCBBAA, 2, 32'h00000000, 1'b0, 1};
    vecs[1]  = '{1'b1, 1'b0, 32'h010, 32'h0,        2, 32'hDDCCBBAA, 1'b0, 1};
    vecs[2]  = '{1'b0, 1'b1, 32'h010, 32'h44332211, 2, 32'hDDCCBBAA, 1'b0, 1};
    vecs[3]  = '{1'b0, 1'b1, 32'h014, 32'h88776655, 2, 32'hDDCCBBAA, 1'b0, 1};
    vecs[4]  = '{1'b1, 1'b0, 32'h013, 32'h0,        3, 32'h77665544, 1'b0, 2};
    vecs[5]  = '{1'b1, 1'b0, 32'h011, 32'h0,        3, 32'h55443322, 1'b0, 2};
    vecs[6]  = '{1'b0, 1'b1, 32'h022, 32'hA1B2C3D4, 3, 32'h55443322, 1'b0, 2};
    vecs[7]  = '{1'b1, 1'b0, 32'h020, 32'h0,        2, 32'hC3D40000, 1'b0, 1};
    vecs[8]  = '{1'b1, 1'b0, 32'h024, 32'h0,        2, 32'h0000A1B2, 1'b0, 1};
    vecs[9]  = '{1'b1, 1'b0, 32'h022, 32'h0,        3, 32'hA1B2C3D4, 1'b0, 2};
    vecs[10] = '{1'b1, 1'b0, 32'hFFE, 32'h0,        1, 32'hA1B2C3D4, 1'b1, 0};
    vecs[11] = '{1'b1, 1'b1, 32'h010, 32'h12345678, 1, 32'hA1B2C3D4, 1'b1, 0};
    vecs[12] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,   1, 32'hA1B2C3D4, 1'b1, 0};
    vecs[13] = '{1'b0, 1'b1, 32'hFFD, 32'hCAFEF00D, 1, 32'hA1B2C3D4, 1'b1, 0};
    vecs[14] = '{1'b1, 1'b0, 32'hFFC, 32'h0,        2, 32'h00000000, 1'b0, 1};
    vecs[15] = '{1'b0, 1'b1, 32'h031, 32'h11223344, 3, 32'h00000000, 1'b0, 2};
    vecs[16] = '{1'b1, 1'b0, 32'h030, 32'h0,        2, 32'h22334400, 1'b0, 1};
    vecs[17] = '{1'b1, 1'b0, 32'h034, 32'h0,        2, 32'h00000011, 1'b0, 1};
    vecs[18] = '{1'b1, 1'b0, 32'h031, 32'h0,        3, 32'h11223344, 1'b0, 2};
    vecs[19] = '{1'b1, 1'b0, 32'h033, 32'h0,        3, 32'h00001122, 1'b0, 2};

    #12;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("reset%0d done", k), 32'(reqDone[k]), 32'h0);
      checkOutput($sformatf("reset%0d err", k), 32'(reqErr[k]), 32'h0);
      checkOutput($sformatf("reset%0d ram_en", k), 32'(ramEn[k]), 32'h0);
      checkOutput($sformatf("reset%0d ram_we", k), 32'(ramWe[k]), 32'h0);
      checkOutput($sformatf("reset%0d rdata", k), reqRdata[k], 32'h0);
    end
    @(negedge clk); memClear = 1'b0; rst = 2'b11;
    @(posedge clk);

    for (int i = 0; i < 20; i++)
      applyStimulus(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].cyc, vecs[i].rdata, vecs[i].err, vecs[i].en, $sformatf("vec%0d", i));

    // Misaligned store split onto the RAM port.
    applyStimulus(0, 1'b0, 1'b1, 32'h22, 32'hA1B2C3D4, 3, 32'h00001122, 1'b0, 2, "st22");
    checkOutput("st22 log size", 32'(accLog.size()), 32'h2);
    if (accLog.size() == 2) begin
      checkOutput("st22 acc1 addr", 32'(accLog[0].addr), 32'h8);
      checkOutput("st22 acc1 be", 32'(accLog[0].be), 32'hC);
      checkOutput("st22 acc1 data", accLog[0].wdata, 32'hC3D40000);
      checkOutput("st22 acc1 we", 32'(accLog[0].we), 32'h1);
      checkOutput("st22 acc2 addr", 32'(accLog[1].addr), 32'h9);
      checkOutput("st22 acc2 be", 32'(accLog[1].be), 32'h3);
      checkOutput("st22 acc2 data", accLog[1].wdata, 32'h0000A1B2);
      checkOutput("st22 acc2 we", 32'(accLog[1].we), 32'h1);
    end

    // Misaligned load reads word 4 then word 5.
    applyStimulus(0, 1'b1, 1'b0, 32'h13, 32'h0, 3, 32'h77665544, 1'b0, 2, "ld13");
    checkOutput("ld13 log size", 32'(accLog.size()), 32'h2);
    if (accLog.size() == 2) begin
      checkOutput("ld13 acc1 addr", 32'(accLog[0].addr), 32'h4);
      checkOutput("ld13 acc2 addr", 32'(accLog[1].addr), 32'h5);
      checkOutput("ld13 acc1 be", 32'(accLog[0].be), 32'hF);
      checkOutput("ld13 acc2 we", 32'(accLog[1].we), 32'h0);
    end

    // Store dropped after one cycle must still finish both halves.
    sbQ.push_back('{cyc: 3, rdata: 32'h77665544, err: 1'b0});
    @(negedge clk);
    reqWrite[0] = 1'b1; reqAddr[0] = 32'h41; reqWdata[0] = 32'h55667788;
    @(posedge clk); #1;
    cyc = 1; got = 0;
    reqWrite[0] = 1'b0;
    if (reqDone[0]) got = 1;
    while (!got && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (reqDone[0]) got = 1;
    end
    checkOutput("drop done seen", 32'(got), 32'h1);
    e = sbQ.pop_front();
    checkOutput("drop cycle", 32'(cyc), 32'(e.cyc));
    checkOutput("drop err", 32'(reqErr[0]), 32'(e.err));
    checkOutput("drop rdata", reqRdata[0], e.rdata);
    @(posedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h41, 32'h0, 3, 32'h55667788, 1'b0, 2, "ld41");

    // A request held through DONE is taken again only from the next IDLE.
    @(negedge clk);
    reqRead[0] = 1'b1; reqAddr[0] = 32'h10;
    cyc = 0;
    while (doneCycs.size() < 2 && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (reqDone[0]) begin
        doneCycs.push_back(cyc);
        checkOutput($sformatf("hold rdata%0d", doneCycs.size()), reqRdata[0], 32'h44332211);
      end
    end
    reqRead[0] = 1'b0;
    checkOutput("hold dones", 32'(doneCycs.size()), 32'h2);
    if (doneCycs.size() == 2) begin
      checkOutput("hold first", 32'(doneCycs[0]), 32'h2);
      checkOutput("hold second", 32'(doneCycs[1]), 32'h5);
    end
    @(posedge clk);

    // Two-wait-state instance.
    applyStimulus(1, 1'b0, 1'b1, 32'h10, 32'h44332211, 4, 32'h0, 1'b0, 3, "ws2 st10");
    applyStimulus(1, 1'b0, 1'b1, 32'h14, 32'h88776655, 4, 32'h0, 1'b0, 3, "ws2 st14");
    applyStimulus(1, 1'b1, 1'b0, 32'h13, 32'h0, 7, 32'h77665544, 1'b0, 6, "ws2 ld13");
    checkOutput("ws2 ld13 log size", 32'(accLog.size()), 32'h6);
    if (accLog.size() == 6) begin
      checkOutput("ws2 ld13 first addr", 32'(accLog[2].addr), 32'h4);
      checkOutput("ws2 ld13 second addr", 32'(accLog[3].addr), 32'h5);
    end
    applyStimulus(1, 1'b1, 1'b1, 32'h10, 32'h0, 1, 32'h77665544, 1'b1, 0, "ws2 rw");

    // Reset asserted in the middle of the second access.
    @(negedge clk);
    reqRead[1] = 1'b1; reqAddr[1] = 32'h13;
    doneSeen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (reqDone[1]) doneSeen++;
    end
    checkOutput("ws2 acc2 ram_en", 32'(ramEn[1]), 32'h1);
    checkOutput("ws2 acc2 addr", 32'(ramAddr[1]), 32'h5);
    rst[1] = 1'b0;
    #1;
    checkOutput("ws2 rst ram_en", 32'(ramEn[1]), 32'h0);
    checkOutput("ws2 rst done", 32'(reqDone[1]), 32'h0);
    checkOutput("ws2 rst rdata", reqRdata[1], 32'h0);
    reqRead[1] = 1'b0;
    @(negedge clk); rst[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (reqDone[1]) doneSeen++;
    end
    checkOutput("ws2 rst no done", 32'(doneSeen), 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h14, 32'h0, 4, 32'h88776655, 1'b0, 3, "ws2 ld14");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 0, extra cycles each RAM access holds ram_en before sampling ram_rdata (0..7).
REQ-002 Parameter MEM_BYTES, default 4096, size of the data address space in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_read  input  1  CPU load request, held until req_done.
REQ-006 req_write  input  1  CPU store request, held until req_done.
REQ-007 req_addr  input  32  byte address, any alignment.
REQ-008 req_wdata  input  32  store data, little-endian.
REQ-009 req_rdata  output  32  load data, valid when req_done=1, held until the next req_done.
REQ-010 req_busy  output  1  high while a request is pending and req_done is low (CPU stall).
REQ-011 req_done  output  1  one-cycle completion pulse.
REQ-012 req_err  output  1  valid with req_done; 1 = address fault or illegal request (Y86 ADR status).
REQ-013 ram_en  output  1  RAM access strobe.
REQ-014 ram_we  output  1  RAM write, qualified by ram_en.
REQ-015 ram_addr  output  30  RAM word address.
REQ-016 ram_be  output  4  byte enables, bit i = byte lane i.
REQ-017 ram_wdata  output  32  RAM write data.
REQ-018 ram_rdata  input  32  RAM read data, valid the cycle after the last ram_en cycle.

Function
REQ-019 FSM states: IDLE, ACC1, ACC2, DONE; IDLE samples a request, ACC1 accesses word addr[31:2], ACC2 accesses word addr[31:2]+1, DONE pulses req_done and returns to IDLE.
REQ-020 Each ACC state holds ram_en=1 for 1+WAIT_STATES cycles, with a counter reset on entry.
REQ-021 Aligned request (addr[1:0]=0) goes IDLE->ACC1->DONE; req_done high in cycle 2+WAIT_STATES counted from the request cycle 0.
REQ-022 Misaligned request goes IDLE->ACC1->ACC2->DONE; req_done high in cycle 3+2*WAIT_STATES.
REQ-023 Load merge: with off=addr[1:0], req_rdata = low 32 bits of ({word1,word0} >> 8*off); ram_be=4'b1111 on reads.
REQ-024 Store split: ACC1 be=(4'b1111<<off)[3:0], data=wdata<<8*off; ACC2 be=4'b1111>>(4-off), data=wdata>>8*(4-off).
REQ-025 Address fault when req_addr+3 >= MEM_BYTES (33-bit sum, no wrap): IDLE->DONE directly, req_err=1, ram_en never asserted, req_rdata unchanged.
REQ-026 req_read and req_write both high: illegal, same handling as REQ-025.
REQ-027 Request dropped before req_done: the access still completes; req_done still pulses; no RAM write is truncated.
REQ-028 In DONE, a new request is not sampled; the earliest next request is accepted in the following IDLE cycle.
REQ-029 ram_en=0, ram_we=0 in IDLE and DONE; ram_addr/ram_be/ram_wdata are don't-care when ram_en=0.

Reset
REQ-030 rst low forces state IDLE, counter 0, req_rdata 0, req_done 0, req_err 0, ram_en 0, ram_we 0, without waiting for clk.
REQ-031 Reset during ACC1/ACC2 abandons the access; no req_done follows; a partially written misaligned store is permitted.

Structure
REQ-032 FSM state encodings, WORD width and the WAIT_STATES default reside in the shared defines file.
REQ-033 Byte-lane shift/merge logic resides in one combinational sub-module, mem_align.

Verification
REQ-034 WAIT_STATES=0, load addr 0x10, RAM word4=0xDDCCBBAA -> done in cycle 2, rdata 0xDDCCBBAA, err 0, one ram_en cycle.
REQ-035 Load addr 0x13, word4=0x44332211, word5=0x88776655 -> two accesses (ram_addr 4,5), done in cycle 3, rdata 0x77665544.
REQ-036 Store 0xA1B2C3D4 to addr 0x22 -> ACC1 ram_addr 8, be 1100, data 0xC3D40000; ACC2 ram_addr 9, be 0011, data 0x0000A1B2.
REQ-037 Load addr 0xFFE with MEM_BYTES=4096 -> done in cycle 1, err 1, ram_en never high; same for read+write together.
REQ-038 WAIT_STATES=2, misaligned load -> ram_en high 3 cycles per word, done in cycle 7; rst pulsed low in ACC2 -> ram_en drops immediately, no done.
